// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave modport is the loader's view; master is the stream source / memory side.
interface imem_loader_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              WE;
  logic [WORD_W-1:0] A;
  logic [WORD_W-1:0] WD;
  logic              cpu_rst;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data,
    input  in_ready, WE, A, WD, cpu_rst, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, WE, A, WD, cpu_rst, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed little-endian byte image, writes it word by
// word into instruction memory from BASE_ADDR, and holds the CPU in reset until done.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BCNT_W = 2;

  typedef enum logic [1:0] {LEN, LOAD, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [WORD_W-1:0]   len_q, len_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   idx_q, idx_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   a_q, a_d;
  logic [WORD_W-1:0]   wd_q, wd_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready;
  logic                accept;

  assign ready  = !rst && (state_q == LEN || state_q == LOAD);
  assign accept = bus.in_valid && ready;

  assign bus.in_ready = ready;
  assign bus.WE       = we_q;
  assign bus.A        = a_q;
  assign bus.WD       = wd_q;
  assign bus.cpu_rst  = cpu_rst_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

  // Next-state and output logic; bytes shift in from the top so byte 0 lands in [7:0]
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    len_d     = len_q;
    word_d    = word_q;
    idx_d     = idx_q;
    we_d      = 1'b0;
    a_d       = a_q;
    wd_d      = wd_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;

    unique case (state_q)
      LEN: begin
        if (accept) begin
          len_d  = {bus.in_data, len_q[WORD_W-1:8]};
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(3)) begin
            if (len_d == '0)                    state_d = DONE;
            else if (len_d > WORD_W'(MAX_WORDS)) state_d = ERR;
            else                                state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          word_d = {bus.in_data, word_q[WORD_W-1:8]};
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(3)) begin
            we_d  = 1'b1;
            wd_d  = word_d;
            a_d   = BASE_ADDR + {idx_q[WORD_W-3:0], 2'b00};
            idx_d = idx_q + WORD_W'(1);
            if (idx_q == len_q - WORD_W'(1)) state_d = DONE;
          end
        end
      end
      // Release lands one edge after the final write is presented, as imem captures it
      DONE: begin
        cpu_rst_d = 1'b0;
        done_d    = 1'b1;
      end
      ERR: begin
        cpu_rst_d = 1'b1;
        err_d     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LEN;
      bcnt_q    <= '0;
      len_q     <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      a_q       <= BASE_ADDR;
      wd_q      <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      len_q     <= len_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      a_q       <= a_d;
      wd_q      <= wd_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
endmodule
